// File: rtl/mdu_pkg.sv
// Shared multiply/divide unit definitions: operation codes, default latencies
// and countdown width, also used by the control and hazard units.
package mdu_pkg;

    typedef enum logic [3:0] {
        MDU_NONE  = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MTHI  = 4'd5,
        MDU_MTLO  = 4'd6,
        MDU_MFHI  = 4'd7,
        MDU_MFLO  = 4'd8
    } mdu_op_e;

    localparam int unsigned MULT_CYCLES_DEF = 5;
    localparam int unsigned DIV_CYCLES_DEF  = 10;
    localparam int unsigned CNT_W           = 4;

    function automatic logic is_long_op(input logic [3:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU) ||
               (op == MDU_DIV)  || (op == MDU_DIVU);
    endfunction

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational multiply/divide datapath; valid drops on divide by zero
// so the sequencer can leave HI/LO untouched.
module mdu_calc
    import mdu_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        valid
);

    logic [63:0] a_ext;
    logic [63:0] b_ext;
    logic [63:0] prod;

    always_comb begin
        hi    = '0;
        lo    = '0;
        valid = 1'b0;
        a_ext = '0;
        b_ext = '0;
        prod  = '0;
        case (mdu_op_e'(op))
            MDU_MULT: begin
                // Low 64 bits of the sign-extended product equal the signed product.
                a_ext = {{32{a[31]}}, a};
                b_ext = {{32{b[31]}}, b};
                prod  = a_ext * b_ext;
                {hi, lo} = prod;
                valid = 1'b1;
            end
            MDU_MULTU: begin
                a_ext = {32'b0, a};
                b_ext = {32'b0, b};
                prod  = a_ext * b_ext;
                {hi, lo} = prod;
                valid = 1'b1;
            end
            MDU_DIV: begin
                if (b != '0) begin
                    valid = 1'b1;
                    if (a == 32'h8000_0000 && b == '1) begin
                        lo = a;
                        hi = '0;
                    end else begin
                        lo = $signed(a) / $signed(b);
                        hi = $signed(a) % $signed(b);
                    end
                end
            end
            MDU_DIVU: begin
                if (b != '0) begin
                    valid = 1'b1;
                    lo = a / b;
                    hi = a % b;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mdu.sv
// E-stage multiply/divide unit: architectural HI/LO, busy countdown that
// models mult/div latency, and the stall request for the hazard unit.
module mdu
    import mdu_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] src_A,
    input  logic [31:0] src_B,
    input  logic [3:0]  MDUOp,
    input  logic        start,
    output logic [31:0] E_MDO,
    output logic        busy,
    output logic        mdu_stall
);

    logic [CNT_W-1:0] count;
    logic [31:0]      hi_q;
    logic [31:0]      lo_q;
    logic [31:0]      pend_hi;
    logic [31:0]      pend_lo;
    logic             pend_valid;

    logic [31:0]      calc_hi;
    logic [31:0]      calc_lo;
    logic             calc_valid;

    mdu_calc u_calc (
        .op    (MDUOp),
        .a     (src_A),
        .b     (src_B),
        .hi    (calc_hi),
        .lo    (calc_lo),
        .valid (calc_valid)
    );

    assign busy      = (count != '0);
    assign mdu_stall = busy | (start & is_long_op(MDUOp));

    always_comb begin
        E_MDO = '0;
        case (mdu_op_e'(MDUOp))
            MDU_MFHI: E_MDO = hi_q;
            MDU_MFLO: E_MDO = lo_q;
            default:  ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            pend_hi    <= '0;
            pend_lo    <= '0;
            pend_valid <= 1'b0;
        end else if (busy) begin
            // New requests are dropped while counting; the result lands on the last tick.
            count <= count - 1'b1;
            if (count == CNT_W'(1) && pend_valid) begin
                hi_q <= pend_hi;
                lo_q <= pend_lo;
            end
        end else if (start) begin
            if (is_long_op(MDUOp)) begin
                pend_hi    <= calc_hi;
                pend_lo    <= calc_lo;
                pend_valid <= calc_valid;
                count      <= is_div_op(MDUOp) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            end else if (MDUOp == MDU_MTHI) begin
                hi_q <= src_A;
            end else if (MDUOp == MDU_MTLO) begin
                lo_q <= src_A;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && busy && start) begin
            assert (!is_long_op(MDUOp) && MDUOp != MDU_MTHI && MDUOp != MDU_MTLO)
                else $error("mdu: op %0d issued while busy", MDUOp);
        end
    end

endmodule
